// File: rtl/gate_count_ctrl.sv
// Gate controller for an external W-bit event counter: conditions evt_in into one
// cnt_en pulse per rising edge, clears the counter per window and latches its count.
module gate_count_ctrl #(
  parameter int W    = 8,
  parameter int TW   = 16,
  parameter int SYNC = 2
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          cont,
  input  logic [TW-1:0] gate_len,
  input  logic          evt_in,
  input  logic [W-1:0]  cnt_q,
  output logic          cnt_en,
  output logic          cnt_sclr_n,
  output logic [W-1:0]  result,
  output logic          result_valid,
  output logic          overflow,
  output logic          busy,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    GATE   = 3'd2,
    SETTLE = 3'd3,
    LATCH  = 3'd4
  } state_t;

  state_t          state;
  logic [SYNC-1:0] sync_q;
  logic            edge_q;
  logic            evt_rise;
  logic [TW-1:0]   len_q;
  logic [TW-1:0]   timer;
  logic            ovf_win;

  assign state_dbg = state;

  // evt_in is asynchronous: metastability chain, then a delayed copy for edge detect.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], evt_in};
      edge_q <= sync_q[SYNC-1];
    end
  end

  assign evt_rise = sync_q[SYNC-1] & ~edge_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state        <= IDLE;
      cnt_en       <= 1'b0;
      cnt_sclr_n   <= 1'b1;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
      timer        <= '0;
      ovf_win      <= 1'b0;
      len_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= CLEAR;
            busy       <= 1'b1;
            cnt_sclr_n <= 1'b0;
            len_q      <= (gate_len == '0) ? TW'(1) : gate_len;
          end
        end
        CLEAR: begin
          state      <= GATE;
          cnt_sclr_n <= 1'b1;
          timer      <= len_q;
          ovf_win    <= 1'b0;
          cnt_en     <= evt_rise;
        end
        GATE: begin
          timer <= timer - TW'(1);
          // An increment issued while the counter already reads all-ones wraps it.
          if (cnt_en && (cnt_q == '1))
            ovf_win <= 1'b1;
          if (timer == TW'(1)) begin
            state  <= SETTLE;
            cnt_en <= 1'b0;
          end else begin
            cnt_en <= evt_rise;
          end
        end
        SETTLE: begin
          state        <= LATCH;
          result       <= ovf_win ? '1 : cnt_q;
          overflow     <= ovf_win;
          result_valid <= 1'b1;
        end
        LATCH: begin
          result_valid <= 1'b0;
          if (cont) begin
            state      <= CLEAR;
            cnt_sclr_n <= 1'b0;
            len_q      <= (gate_len == '0) ? TW'(1) : gate_len;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          cnt_en       <= 1'b0;
          cnt_sclr_n   <= 1'b1;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
